tone_decoder: RTL and testbench
===============================

# tone_decoder

Receive-side companion to the switch-driven piano tone generator. It samples a square-wave audio line (the generator's speaker output, or a comparator on a microphone) at the 20 kHz tone frame rate and measures the period between rising edges. It classifies that period against the six-note period table and reports a stable note index once the same note has repeated for several consecutive periods. It sits between the board audio input pin and the LED/display logic.

## Interface
- TICK_DIV, 2500, CLK cycles per sample tick (50 MHz / 2500 = 20 kHz)
- TOL, 2, allowed ± deviation in ticks between measured period and table entry
- LOCK_CNT, 4, consecutive matching periods required to assert VALID (1..15)

- CLK  input  1  system clock
- RST  input  1  reset RST, synchronous, active-high; clock CLK
- TONE_IN  input  1  asynchronous square-wave input
- NOTE  output  3  decoded note index 0..5; holds the last locked value
- VALID  output  1  high while a note is locked
- PERIOD  output  8  last measured period in ticks, saturating at 255
- LED  output  6  one-hot of NOTE when VALID; all zero otherwise

## Operation
- Period table, index 0..5 in ticks: 152, 136, 121, 115, 102, 91.
- TONE_IN passes through a 2-FF synchronizer on CLK.
- Prescaler counts 0..TICK_DIV-1 and wraps. The tick is high for the one cycle where count == TICK_DIV-1.
- On each tick the synchronized value is sampled into s, and the previous sample is kept in s_prev. A rising edge means s=1 and s_prev=0 on a tick.
- Tick counter cnt, 8 bits:
  - cleared to 0 on a rising-edge tick;
  - otherwise incremented on each tick, saturating at 255.
- On a rising-edge tick:
  - measured period m = min(cnt+1, 255); PERIOD <= m.
  - class c = the lowest index i with |m − P[i]| ≤ TOL, else NONE.
  - m = 255 always yields NONE.
- FSM states SILENT, ACQUIRE, LOCKED. Transitions are evaluated only on rising-edge ticks, except timeout.
  - SILENT, c valid: go to ACQUIRE with cand=c, match=1.
  - SILENT, c = NONE: stay in SILENT.
  - ACQUIRE, c == cand: match+1. If the new match equals LOCK_CNT, go to LOCKED and set NOTE=cand.
  - ACQUIRE, c valid and ≠ cand: restart with cand=c, match=1.
  - ACQUIRE, c = NONE: go to SILENT.
  - LOCKED, c == NOTE: stay in LOCKED.
  - LOCKED, c valid and ≠ NOTE: go to ACQUIRE with cand=c, match=1.
  - LOCKED, c = NONE: go to SILENT.
- Timeout: in any state, a tick where cnt becomes 255 and no edge occurs forces SILENT.
- VALID = (state == LOCKED). LED = VALID ? (1 << NOTE) : 0.

## Timing
- Reset values:
  - NOTE=0, VALID=0, PERIOD=0, LED=0;
  - state SILENT, cnt=255 (so the first edge after reset measures NONE), prescaler=0;
  - s=s_prev=0, synchronizer=0.
- RST mid-operation overrides everything on the next CLK edge. Decoding restarts from SILENT.
- Input-to-sample latency: 2 CLK cycles of synchronizer, plus up to TICK_DIV cycles until the next tick.
- NOTE, VALID, PERIOD and LED are registered. They change on the CLK edge that ends the tick cycle in which the deciding edge or timeout is detected.
- Lock requires LOCK_CNT+1 rising edges from silence: the first edge only starts the measurement.
- VALID drops on the first mismatching edge. NOTE is not cleared when VALID drops.
- Timeout occurs 255 ticks after the last rising edge.

## Configuration
- TONE_DECODER_GLITCH_FILTER_EN defined:
  - s is the majority of the last three tick samples of the synchronized input;
  - single-tick glitches are rejected;
  - edges are delayed by 1 tick; measured periods are unchanged.
- TONE_DECODER_GLITCH_FILTER_EN undefined: s is the raw synchronized value at the tick.

## Test plan
- Use TICK_DIV=4 and defaults for all scenarios.
- 50%-duty square wave with period 152 ticks: VALID=1, NOTE=0, LED=6'b000001 after the 5th rising edge; PERIOD=152.
- Period 91 ticks: NOTE=5, LED=6'b100000 after 5 edges. Period 118 ticks: class NONE, VALID stays 0, PERIOD=118.
- Locked on 152, then switched to 136: VALID=0 at the first 136 period while NOTE stays 0; VALID=1 with NOTE=1 at the 4th 136 period.
- Locked, then TONE_IN held low: VALID=0 exactly 255 ticks after the last rising edge. Assert RST mid-lock: all outputs at reset values on the next cycle.
- Filter enabled, locked on 121 with a single-tick high glitch injected mid low phase: VALID stays 1 and NOTE stays 2.
- Filter disabled, same stimulus: VALID drops.

Source files
------------

// File: rtl/tone_decoder.sv
// tone_decoder: measures the rising-edge period of a tick-sampled square wave and locks onto one of six notes.
// Build option: define TONE_DECODER_GLITCH_FILTER_EN for a 3-sample majority filter on the tick samples.
module tone_decoder #(
    parameter int TICK_DIV = 2500,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TONE_IN,
    output logic [2:0] NOTE,
    output logic       VALID,
    output logic [7:0] PERIOD,
    output logic [5:0] LED
);
    localparam int         PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [2:0] CLS_NONE = 3'd7;

    typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;

    logic [1:0]    r_sync;
    logic [PW-1:0] r_presc;
    logic          r_s;
    logic [7:0]    r_cnt;
    state_t        r_state;
    logic [2:0]    r_cand;
    logic [3:0]    r_match;
    logic [2:0]    r_note;
    logic          r_valid;
    logic [7:0]    r_period;
    logic [5:0]    r_led;

    logic       w_tick;
    logic       w_s_new;
    logic       w_rise;
    logic       w_timeout;
    logic       w_cls_ok;
    logic [7:0] w_m;
    logic [2:0] w_cls;

    function automatic logic [7:0] note_period(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'd152;
            3'd1:    return 8'd136;
            3'd2:    return 8'd121;
            3'd3:    return 8'd115;
            3'd4:    return 8'd102;
            default: return 8'd91;
        endcase
    endfunction

    function automatic logic in_tol(input logic [7:0] m, input logic [7:0] p);
        int d;
        d = int'(m) - int'(p);
        return (d <= TOL) && (d >= -TOL);
    endfunction

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

`ifdef TONE_DECODER_GLITCH_FILTER_EN
    logic [1:0] r_hist;

    always_ff @(posedge CLK) begin
        if (RST)
            r_hist <= '0;
        else if (w_tick)
            r_hist <= {r_hist[0], r_sync[1]};
    end

    assign w_s_new = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_s_new = r_sync[1];
`endif

    // r_s holds the previous tick sample, so a rise is new=1 over old=0.
    assign w_rise    = w_tick & w_s_new & ~r_s;
    assign w_m       = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_timeout = w_tick & ~w_rise & (w_m == 8'hFF);

    always_comb begin
        w_cls = CLS_NONE;
        for (int i = 5; i >= 0; i--) begin
            if (w_m != 8'hFF && in_tol(w_m, note_period(3'(i))))
                w_cls = 3'(i);
        end
    end

    assign w_cls_ok = (w_cls != CLS_NONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync   <= '0;
            r_presc  <= '0;
            r_s      <= 1'b0;
            r_cnt    <= 8'hFF;
            r_state  <= SILENT;
            r_cand   <= '0;
            r_match  <= '0;
            r_note   <= '0;
            r_valid  <= 1'b0;
            r_period <= '0;
            r_led    <= '0;
        end else begin
            r_sync  <= {r_sync[0], TONE_IN};
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_s   <= w_s_new;
                r_cnt <= w_rise ? 8'd0 : w_m;
            end
            if (w_timeout) begin
                r_state <= SILENT;
                r_valid <= 1'b0;
                r_led   <= '0;
            end else if (w_rise) begin
                r_period <= w_m;
                case (r_state)
                    SILENT: begin
                        if (w_cls_ok) begin
                            r_state <= ACQUIRE;
                            r_cand  <= w_cls;
                            r_match <= 4'd1;
                        end
                    end
                    ACQUIRE: begin
                        if (!w_cls_ok) begin
                            r_state <= SILENT;
                        end else if (w_cls == r_cand) begin
                            r_match <= r_match + 4'd1;
                            if (r_match + 4'd1 >= 4'(LOCK_CNT)) begin
                                r_state <= LOCKED;
                                r_note  <= r_cand;
                                r_valid <= 1'b1;
                                r_led   <= 6'd1 << r_cand;
                            end
                        end else begin
                            r_cand  <= w_cls;
                            r_match <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        // NOTE is kept when the lock is lost; only VALID and LED drop.
                        if (!w_cls_ok) begin
                            r_state <= SILENT;
                            r_valid <= 1'b0;
                            r_led   <= '0;
                        end else if (w_cls != r_note) begin
                            r_state <= ACQUIRE;
                            r_cand  <= w_cls;
                            r_match <= 4'd1;
                            r_valid <= 1'b0;
                            r_led   <= '0;
                        end
                    end
                    default: r_state <= SILENT;
                endcase
            end
        end
    end

    assign NOTE   = r_note;
    assign VALID  = r_valid;
    assign PERIOD = r_period;
    assign LED    = r_led;
endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: tick-aligned square-wave stimulus, a run-length reference model and directed scenarios.
module tb_tone_decoder;
    localparam int TICK_DIV = 4;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 4;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
    localparam int FD = 1;
`else
    localparam int FD = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TONE_IN = 1'b0;
    logic [2:0] NOTE;
    logic       VALID;
    logic [7:0] PERIOD;
    logic [5:0] LED;

    int n_tests = 0;
    int n_fail  = 0;

    int table_p[6] = '{152, 136, 121, 115, 102, 91};

    // reference model state
    int m_since;
    int m_run;
    int m_cls;
    int m_note;
    int m_period;
    bit m_sprev;
    bit m_h1;
    bit m_h2;

    tone_decoder #(
        .TICK_DIV(TICK_DIV),
        .TOL     (TOL),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .TONE_IN(TONE_IN),
        .NOTE   (NOTE),
        .VALID  (VALID),
        .PERIOD (PERIOD),
        .LED    (LED)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input int m);
        if (m >= 255) return -1;
        for (int i = 0; i < 6; i++) begin
            if (m - table_p[i] <= TOL && table_p[i] - m <= TOL) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_since  = 255;
        m_run    = 0;
        m_cls    = 0;
        m_note   = 0;
        m_period = 0;
        m_sprev  = 1'b0;
        m_h1     = 1'b0;
        m_h2     = 1'b0;
    endtask

    // Lock = a run of LOCK_CNT identical valid classes; NONE or 255 silent ticks break the run.
    task automatic model_step(input bit raw);
        bit s;
        int mv;
        int c;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
        s = (int'(raw) + int'(m_h1) + int'(m_h2)) >= 2;
        m_h2 = m_h1;
        m_h1 = raw;
`else
        s = raw;
`endif
        if (s && !m_sprev) begin
            mv = (m_since + 1 > 255) ? 255 : m_since + 1;
            m_since  = 0;
            m_period = mv;
            c = classify(mv);
            if (c < 0) begin
                m_run = 0;
            end else if (m_run > 0 && c == m_cls) begin
                if (m_run < LOCK_CNT) m_run++;
            end else begin
                m_cls = c;
                m_run = 1;
            end
            if (m_run >= LOCK_CNT) m_note = m_cls;
        end else if (m_since < 255) begin
            m_since++;
            if (m_since == 255) m_run = 0;
        end
        m_sprev = s;
    endtask

    task automatic slot(input bit v);
        int ev;
        TONE_IN = v;
        repeat (TICK_DIV) @(posedge CLK);
        @(negedge CLK);
        model_step(v);
        ev = (m_run >= LOCK_CNT) ? 1 : 0;
        check("m_valid", int'(VALID), ev);
        check("m_note", int'(NOTE), m_note);
        check("m_period", int'(PERIOD), m_period);
        check("m_led", int'(LED), ev ? (1 << m_note) : 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST = 1'b1;
        repeat (n) @(posedge CLK);
        @(negedge CLK);
        check("rst_note", int'(NOTE), 0);
        check("rst_valid", int'(VALID), 0);
        check("rst_period", int'(PERIOD), 0);
        check("rst_led", int'(LED), 0);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic call_period(input int p, input int h);
        for (int i = 0; i < h; i++) slot(1'b1);
        for (int i = 0; i < p - h; i++) slot(1'b0);
    endtask

    task automatic call_glitch(input int p, input int h, input int gpos);
        for (int i = 0; i < h; i++) slot(1'b1);
        for (int i = 0; i < p - h; i++) slot(i == gpos);
    endtask

    task automatic drive_low(input int n);
        for (int i = 0; i < n; i++) slot(1'b0);
    endtask

    initial begin
        int p;
        int h;
        int reps;
        model_reset();
        do_reset(3);

        // lock on 152, then move to 136, then time out
        for (int k = 0; k < 4; k++) call_period(152, 76);
        check("A_valid_pre", int'(VALID), 0);
        call_period(152, 76);
        check("A_valid", int'(VALID), 1);
        check("A_note", int'(NOTE), 0);
        check("A_led", int'(LED), 1);
        check("A_period", int'(PERIOD), 152);
        call_period(136, 68);
        check("D_still_locked", int'(VALID), 1);
        call_period(136, 68);
        check("D_drop_valid", int'(VALID), 0);
        check("D_hold_note", int'(NOTE), 0);
        check("D_period", int'(PERIOD), 136);
        check("D_drop_led", int'(LED), 0);
        call_period(136, 68);
        call_period(136, 68);
        check("D_acq_valid", int'(VALID), 0);
        call_period(136, 68);
        check("D_relock_valid", int'(VALID), 1);
        check("D_relock_note", int'(NOTE), 1);
        check("D_relock_led", int'(LED), 2);
        drive_low(119 + FD);
        check("T_before", int'(VALID), 1);
        drive_low(1);
        check("T_valid", int'(VALID), 0);
        check("T_note_hold", int'(NOTE), 1);
        check("T_led", int'(LED), 0);

        // lock on 91, then reset in the middle of the lock
        do_reset(3);
        for (int k = 0; k < 5; k++) call_period(91, 45);
        check("B_valid", int'(VALID), 1);
        check("B_note", int'(NOTE), 5);
        check("B_led", int'(LED), 32);
        check("B_period", int'(PERIOD), 91);
        do_reset(1);

        // 118 ticks is between table entries
        for (int k = 0; k < 6; k++) call_period(118, 59);
        check("C_valid", int'(VALID), 0);
        check("C_period", int'(PERIOD), 118);

        // glitch in the low phase of a 121-tick lock
        do_reset(3);
        for (int k = 0; k < 5; k++) call_period(121, 60);
        check("G_lock_valid", int'(VALID), 1);
        check("G_lock_note", int'(NOTE), 2);
        call_glitch(121, 60, 30);
        check("G_glitch_valid", int'(VALID), FD);
        call_period(121, 60);
        check("G_after_valid", int'(VALID), FD);
        check("G_after_note", int'(NOTE), FD ? 2 : int'(NOTE) == 5 ? 5 : 2);

        // randomized periods, duty cycles and silences
        do_reset(3);
        for (int seg = 0; seg < 14; seg++) begin
            if ($urandom_range(0, 1) == 1)
                p = table_p[$urandom_range(0, 5)] + int'($urandom_range(0, 6)) - 3;
            else
                p = int'($urandom_range(40, 180));
            reps = int'($urandom_range(1, 4));
            for (int r = 0; r < reps; r++) begin
                h = int'($urandom_range(3, p - 3));
                call_period(p, h);
            end
            if ($urandom_range(0, 3) == 0) drive_low(int'($urandom_range(200, 280)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
